mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single IO/memory master port between the CPU's instruction-fetch port and data-access port. Sits between the pipeline's IF and MEM stages and the address decoder that dispatches to RAM and serial. Serialises requests and inserts a fixed number of SRAM wait states. Returns read data with a one-cycle ready pulse that the pipeline uses as its stall-release.

## Interface
- WAIT_CYCLES, default 2: extra cycles the bus request is held beyond the first. Legal range 0..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_mode  in  4  fetch access code; 0 = no request, any nonzero value = request, passed through unchanged.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetch read data.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- mem_mode  in  4  data access code; 0 = no request.
- mem_addr  in  32  data address.
- mem_wdata  in  32  data write value.
- mem_rdata  out  32  data read data.
- mem_ready  out  1  one-cycle completion pulse for the data port.
- bus_mode  out  4  mode to the address decoder; 0 when idle.
- bus_addr  out  32  address to the decoder.
- bus_wdata  out  32  write data to the decoder.
- bus_rdata  in  32  read data from the decoder, combinational from bus_addr.

## Operation
- Requester rule: keep mode nonzero and addr/wdata stable until its ready pulses. Mode may be dropped only in or after the ready cycle.
- States:
  - IDLE: sample requests. If none, stay.
  - ACCESS: bus driven from latched registers. Counter runs 0..WAIT_CYCLES. At count == WAIT_CYCLES, capture bus_rdata into the granted port's rdata register and go to DONE.
  - DONE: assert the granted port's ready. bus_mode = 0 (one-cycle turnaround for SRAM WE/OE). Next state IDLE.
- Arbitration in IDLE:
  - One port requesting: grant it.
  - Both requesting: grant the port not in last_grant (round-robin). last_grant updates on each grant.
- On grant: latch mode, addr and wdata (wdata forced 0 for fetch) into bus registers. Latch grant id.
- A requester that drops its mode mid-ACCESS does not abort the access. It completes and ready still pulses.
- Non-granted port's rdata holds its previous value. Its ready stays 0.
- Writes also capture bus_rdata. Value is don't-care to requester but is deterministic.

## Timing
- Reset values:
  - state = IDLE, counter = 0, last_grant = IF (so data wins the first contention).
  - bus_mode = 0, bus_addr = 0, bus_wdata = 0.
  - if_rdata = mem_rdata = 0, if_ready = mem_ready = 0.
- Latency: request seen in IDLE at cycle T. bus_mode is nonzero in cycles T+1 .. T+1+WAIT_CYCLES. Ready is high in cycle T+2+WAIT_CYCLES; rdata is valid from that cycle on.
- Throughput: one access per WAIT_CYCLES+3 cycles. Back-to-back alternating grants under continuous contention.
- WAIT_CYCLES = 0: bus driven exactly one cycle.
- Ready is always exactly one cycle wide. if_ready and mem_ready are never high together.
- Reset asserted in any state: all outputs take reset values at the next edge. In-flight access is discarded with no ready pulse.
- Counter width is 4 bits. It never wraps, because it stops at WAIT_CYCLES.

## Structure
- Shared package holds:
  - MODE_NONE = 4'h0.
  - State encoding IDLE / ACCESS / DONE.
  - Port id constants PORT_IF / PORT_MEM.
- One sub-module: bus_wait_timer (start, done; counts WAIT_CYCLES+1 cycles). It is reused later by flash and ethernet controllers.
- Arbitration logic and rdata registers stay in the top module.

## Test plan
- Single fetch, WAIT_CYCLES=2: if_mode=1, if_addr=0x80000000 at T; bus_rdata=0x24020001.
  - Expect bus_mode=1 in T+1..T+3.
  - Expect if_ready=1 and if_rdata=0x24020001 at T+4.
  - bus_mode=0 at T+4.
- Data write: mem_mode=nonzero, mem_addr=0xBFD003F8, mem_wdata=0x41.
  - Expect bus_addr=0xBFD003F8 and bus_wdata=0x41 held for 3 cycles.
  - mem_ready pulses once; if_ready stays 0.
- Contention from reset: both ports request in the same cycle.
  - Data granted first; fetch granted in the next IDLE.
  - Third simultaneous request goes to data.
  - No cycle has both readys high.
- Requester drops if_mode one cycle after grant: access still completes and if_ready pulses at T+4.
- rst_n low during ACCESS: next edge bus_mode=0 and state IDLE. No ready pulse. if_rdata=0.
- WAIT_CYCLES=0 build: ready at T+2. Continuous fetch stream yields one if_ready every 3 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the fetch/data bus arbiter and its wait-state timer.
package mem_bus_arbiter_pkg;

  localparam logic [3:0] MODE_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_id_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the pipeline IF/MEM ports, the arbiter and the address decoder.
interface mem_bus_arbiter_if;

  logic [3:0]  if_mode;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic [3:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [3:0]  bus_mode;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  // The arbiter is the slave of the pipeline ports and drives the decoder side.
  modport slave (
    input  if_mode, if_addr, mem_mode, mem_addr, mem_wdata, bus_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, bus_mode, bus_addr, bus_wdata
  );

  modport master (
    output if_mode, if_addr, mem_mode, mem_addr, mem_wdata, bus_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, bus_mode, bus_addr, bus_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_wait_timer.sv
// Wait-state timer: after a start pulse, done_o rises in the (WAIT_CYCLES+1)-th cycle.
// Shared with the flash and ethernet controllers, so it knows nothing about arbitration.
module bus_wait_timer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o
);

  localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES);

  logic [3:0] count_q, count_d;
  logic       running_q, running_d;

  // Counter parks at LAST_COUNT once done, so it can never wrap.
  always_comb begin
    count_d   = count_q;
    running_d = running_q;
    if (start_i) begin
      count_d   = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      if (count_q == LAST_COUNT) begin
        running_d = 1'b0;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

  assign done_o = running_q && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one decoder bus between instruction fetch and data access,
// with fixed SRAM wait states and a one-cycle ready pulse per completed access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e  state_q;
  port_id_e    grant_q, last_grant_q, grant_d;
  logic        grant_valid_d;
  logic [3:0]  bus_mode_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        if_ready_q, mem_ready_q;
  logic        if_req, mem_req, timer_start, timer_done;

  assign if_req  = (bus.if_mode != MODE_NONE);
  assign mem_req = (bus.mem_mode != MODE_NONE);

  // Under contention the port that did not win last time is served.
  always_comb begin
    grant_valid_d = if_req || mem_req;
    grant_d       = PORT_IF;
    if (if_req && mem_req) begin
      grant_d = (last_grant_q == PORT_IF) ? PORT_MEM : PORT_IF;
    end else if (mem_req) begin
      grant_d = PORT_MEM;
    end
  end

  assign timer_start = (state_q == IDLE) && grant_valid_d;

  bus_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(timer_start),
    .done_o (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= PORT_IF;
      last_grant_q <= PORT_IF;
      bus_mode_q   <= MODE_NONE;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            state_q      <= ACCESS;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            if (grant_d == PORT_MEM) begin
              bus_mode_q  <= bus.mem_mode;
              bus_addr_q  <= bus.mem_addr;
              bus_wdata_q <= bus.mem_wdata;
            end else begin
              bus_mode_q  <= bus.if_mode;
              bus_addr_q  <= bus.if_addr;
              bus_wdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          // Dropping bus_mode in DONE gives the SRAM a WE/OE turnaround cycle.
          if (timer_done) begin
            state_q    <= DONE;
            bus_mode_q <= MODE_NONE;
            if (grant_q == PORT_MEM) begin
              mem_rdata_q <= bus.bus_rdata;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.bus_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_mode  = bus_mode_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 arbiter driven side by side
// and compared every cycle against a transaction-timeline model.
module tb_mem_bus_arbiter;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  ifMode    [NDUT];
  logic [31:0] ifAddr    [NDUT];
  logic [3:0]  memMode   [NDUT];
  logic [31:0] memAddr   [NDUT];
  logic [31:0] memWdata  [NDUT];
  logic [3:0]  busMode   [NDUT];
  logic [31:0] busAddr   [NDUT];
  logic [31:0] busWdata  [NDUT];
  logic [31:0] ifRdata   [NDUT];
  logic [31:0] memRdata  [NDUT];
  logic        ifReady   [NDUT];
  logic        memReady  [NDUT];

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  bit randomOn = 1'b0;
  bit streamOn = 1'b0;

  // Model: one access = grant cycle g, bus busy g+1..g+1+W, ready at g+2+W, idle from g+3+W.
  bit          mActive     [NDUT];
  int          mGrantAt    [NDUT];
  bit          mGrantMem   [NDUT];
  bit          mLastMem    [NDUT];
  logic [3:0]  mMode       [NDUT];
  logic [31:0] mAddr       [NDUT];
  logic [31:0] mWdata      [NDUT];
  logic [31:0] expIfRdata  [NDUT];
  logic [31:0] expMemRdata [NDUT];
  bit          mIfDone     [NDUT];
  bit          mMemDone    [NDUT];
  bit          rqIfBusy    [NDUT];
  bit          rqMemBusy   [NDUT];
  bit          rqIfDrop    [NDUT];
  bit          rqMemDrop   [NDUT];

  function automatic logic [31:0] busReadValue(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h2402_0001;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int waitOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    mem_bus_arbiter_if busIf ();

    mem_bus_arbiter #(
      .WAIT_CYCLES(g == 0 ? 2 : 0)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (busIf.slave)
    );

    assign busIf.if_mode   = ifMode[g];
    assign busIf.if_addr   = ifAddr[g];
    assign busIf.mem_mode  = memMode[g];
    assign busIf.mem_addr  = memAddr[g];
    assign busIf.mem_wdata = memWdata[g];
    assign busIf.bus_rdata = busReadValue(busIf.bus_addr);
    assign busMode[g]      = busIf.bus_mode;
    assign busAddr[g]      = busIf.bus_addr;
    assign busWdata[g]     = busIf.bus_wdata;
    assign ifRdata[g]      = busIf.if_rdata;
    assign memRdata[g]     = busIf.mem_rdata;
    assign ifReady[g]      = busIf.if_ready;
    assign memReady[g]     = busIf.mem_ready;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
    end
  endtask

  task automatic checkDut(input int d);
    int w, k;
    logic [3:0] eMode;
    logic eIfReady, eMemReady;
    w = waitOf(d);
    eMode = 4'h0;
    eIfReady = 1'b0;
    eMemReady = 1'b0;
    mIfDone[d] = 1'b0;
    mMemDone[d] = 1'b0;
    if (mActive[d]) begin
      k = cyc - mGrantAt[d];
      if (k >= 1 && k <= w + 1) eMode = mMode[d];
      if (k == w + 2) begin
        if (mGrantMem[d]) begin
          eMemReady = 1'b1;
          mMemDone[d] = 1'b1;
          expMemRdata[d] = busReadValue(mAddr[d]);
        end else begin
          eIfReady = 1'b1;
          mIfDone[d] = 1'b1;
          expIfRdata[d] = busReadValue(mAddr[d]);
        end
      end
      if (k >= w + 3) mActive[d] = 1'b0;
    end
    checkOutput($sformatf("dut%0d busMode", d), 32'(busMode[d]), 32'(eMode));
    checkOutput($sformatf("dut%0d busAddr", d), busAddr[d], mAddr[d]);
    checkOutput($sformatf("dut%0d busWdata", d), busWdata[d], mWdata[d]);
    checkOutput($sformatf("dut%0d ifReady", d), 32'(ifReady[d]), 32'(eIfReady));
    checkOutput($sformatf("dut%0d memReady", d), 32'(memReady[d]), 32'(eMemReady));
    checkOutput($sformatf("dut%0d ifRdata", d), ifRdata[d], expIfRdata[d]);
    checkOutput($sformatf("dut%0d memRdata", d), memRdata[d], expMemRdata[d]);
    checkOutput($sformatf("dut%0d bothReady", d), 32'(ifReady[d] & memReady[d]), 32'h0);
  endtask

  task automatic startFetch(input int d, input logic [3:0] mode, input logic [31:0] addr, input bit drop);
    rqIfBusy[d] = 1'b1;
    rqIfDrop[d] = drop;
    ifMode[d] = mode;
    ifAddr[d] = addr;
  endtask

  task automatic startData(input int d, input logic [3:0] mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop);
    rqMemBusy[d] = 1'b1;
    rqMemDrop[d] = drop;
    memMode[d] = mode;
    memAddr[d] = addr;
    memWdata[d] = wdata;
  endtask

  // Requesters hold their request until ready, optionally dropping mode right after grant.
  task automatic applyStimulus(input int d);
    if (mIfDone[d]) begin
      rqIfBusy[d] = 1'b0;
      ifMode[d] = 4'h0;
      if (streamOn || (randomOn && $urandom_range(1) == 1))
        startFetch(d, 4'($urandom_range(15, 1)), $urandom, randomOn && ($urandom_range(3) == 0));
    end else if (rqIfBusy[d]) begin
      if (rqIfDrop[d] && mActive[d] && !mGrantMem[d] && cyc == mGrantAt[d] + 1) ifMode[d] = 4'h0;
    end else if (randomOn && $urandom_range(2) == 0) begin
      startFetch(d, 4'($urandom_range(15, 1)), $urandom, $urandom_range(3) == 0);
    end

    if (mMemDone[d]) begin
      rqMemBusy[d] = 1'b0;
      memMode[d] = 4'h0;
      if (streamOn || (randomOn && $urandom_range(1) == 1))
        startData(d, 4'($urandom_range(15, 1)), $urandom, $urandom, randomOn && ($urandom_range(3) == 0));
    end else if (rqMemBusy[d]) begin
      if (rqMemDrop[d] && mActive[d] && mGrantMem[d] && cyc == mGrantAt[d] + 1) memMode[d] = 4'h0;
    end else if (randomOn && $urandom_range(2) == 0) begin
      startData(d, 4'($urandom_range(15, 1)), $urandom, $urandom, $urandom_range(3) == 0);
    end
  endtask

  task automatic arbitrateModel();
    bit reqI, reqM, useMem;
    for (int d = 0; d < NDUT; d++) begin
      reqI = (ifMode[d] != 4'h0);
      reqM = (memMode[d] != 4'h0);
      if (!mActive[d] && (reqI || reqM)) begin
        useMem = reqM && (!reqI || !mLastMem[d]);
        mActive[d] = 1'b1;
        mGrantAt[d] = cyc;
        mGrantMem[d] = useMem;
        mLastMem[d] = useMem;
        mMode[d] = useMem ? memMode[d] : ifMode[d];
        mAddr[d] = useMem ? memAddr[d] : ifAddr[d];
        mWdata[d] = useMem ? memWdata[d] : 32'h0;
      end
    end
  endtask

  task automatic cycleStep();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) checkDut(d);
    for (int d = 0; d < NDUT; d++) applyStimulus(d);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      cycleStep();
      arbitrateModel();
    end
  endtask

  // Reset is sampled at the next edge; outputs are checked against reset values right after it.
  task automatic resetAll();
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      ifMode[d] = 4'h0;  ifAddr[d] = 32'h0;
      memMode[d] = 4'h0; memAddr[d] = 32'h0; memWdata[d] = 32'h0;
      rqIfBusy[d] = 1'b0; rqMemBusy[d] = 1'b0;
      rqIfDrop[d] = 1'b0; rqMemDrop[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      mActive[d] = 1'b0;   mGrantAt[d] = 0;
      mGrantMem[d] = 1'b0; mLastMem[d] = 1'b0;
      mMode[d] = 4'h0;     mAddr[d] = 32'h0;   mWdata[d] = 32'h0;
      expIfRdata[d] = 32'h0; expMemRdata[d] = 32'h0;
      checkDut(d);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    resetAll();

    // Single fetch, then a single data write.
    cycleStep();
    for (int d = 0; d < NDUT; d++) startFetch(d, 4'h1, 32'h8000_0000, 1'b0);
    arbitrateModel();
    runCycles(7);
    cycleStep();
    for (int d = 0; d < NDUT; d++) startData(d, 4'h9, 32'hBFD0_03F8, 32'h0000_0041, 1'b0);
    arbitrateModel();
    runCycles(7);

    // Continuous contention straight out of reset.
    resetAll();
    streamOn = 1'b1;
    cycleStep();
    for (int d = 0; d < NDUT; d++) begin
      startFetch(d, 4'h1, $urandom, 1'b0);
      startData(d, 4'h5, $urandom, $urandom, 1'b0);
    end
    arbitrateModel();
    runCycles(24);
    streamOn = 1'b0;
    runCycles(14);

    // Fetch requester abandons mode one cycle after grant.
    cycleStep();
    for (int d = 0; d < NDUT; d++) startFetch(d, 4'h2, 32'h0000_1000, 1'b1);
    arbitrateModel();
    runCycles(7);

    // Reset while an access is in flight.
    cycleStep();
    for (int d = 0; d < NDUT; d++) startFetch(d, 4'h1, 32'h0040_0000, 1'b0);
    arbitrateModel();
    runCycles(2);
    resetAll();
    runCycles(4);

    randomOn = 1'b1;
    runCycles(800);
    randomOn = 1'b0;
    runCycles(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
